mem_data_req: RTL and testbench

MEM-stage data-memory request controller, directly downstream of the execute stage. It takes the execute stage's memory operation (address from the ALU, store data, access size) and issues it on an SRAM-like data bus with an address/data two-phase handshake. It formats store strobes and load results and stalls the pipeline until the access completes. It also handles flushes that arrive while a transaction is outstanding.

---
 rtl/mem_data_req.sv | 172 +++++++++++++++++
 tb/tb_mem_data_req.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_req.sv
// MEM-stage data-memory request controller: issues execute-stage loads/stores on an
// SRAM-like address/data handshake bus, formats strobes and load data, and stalls the pipe.
module mem_data_req (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  input  logic [1:0]  exe_op,
  input  logic [1:0]  exe_size,
  input  logic        exe_sign,
  input  logic [31:0] exe_addr,
  input  logic [31:0] exe_wdata,
  input  logic        exe_except,
  input  logic        mem_flush,
  input  logic        mem_adv,
  output logic        mem_ade,
  output logic        mem_stall,
  output logic        load_valid,
  output logic [31:0] load_result,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;

  logic        op_mem;
  logic        accept;
  logic [31:0] rdata_shifted;
  logic [31:0] load_fmt;

  assign op_mem = exe_valid && (exe_op == 2'b01 || exe_op == 2'b10);

  always_comb begin
    unique case (exe_size)
      2'd0:    mem_ade = 1'b0;
      2'd1:    mem_ade = exe_addr[0];
      default: mem_ade = |exe_addr[1:0];
    endcase
    mem_ade = mem_ade && op_mem;
  end

  assign accept = op_mem && !exe_except && !mem_ade && !mem_flush &&
                  (state_q == S_IDLE || (state_q == S_DONE && mem_adv));

  // Byte lane of the addressed datum moved down to bit 0 before extension.
  assign rdata_shifted = data_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    unique case (size_q)
      2'd0:    load_fmt = {{24{sign_q && rdata_shifted[7]}},  rdata_shifted[7:0]};
      2'd1:    load_fmt = {{16{sign_q && rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_fmt = rdata_shifted;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    sign_d   = sign_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        // A same-cycle data_ok cannot belong to this request and is ignored.
        if (mem_flush)         state_d = data_addr_ok ? S_DISCARD : S_IDLE;
        else if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_flush) begin
          state_d = data_data_ok ? S_IDLE : S_DISCARD;
        end else if (data_data_ok) begin
          state_d  = S_DONE;
          result_d = load_fmt;
        end
      end
      S_DONE: begin
        if (mem_flush)    state_d = S_IDLE;
        else if (accept)  state_d = S_REQ;
        else if (mem_adv) state_d = S_IDLE;
      end
      S_DISCARD: begin
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      wr_d    = (exe_op == 2'b10);
      size_d  = exe_size;
      sign_d  = exe_sign;
      addr_d  = exe_addr;
      wdata_d = exe_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      sign_q   <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
    end
  end

  assign data_req    = (state_q == S_REQ);
  assign data_wr     = wr_q;
  assign data_size   = size_q;
  assign data_addr   = addr_q;
  assign load_valid  = (state_q == S_DONE) && !wr_q;
  assign load_result = result_q;

  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = wdata_q;
    unique case (size_q)
      2'd0: begin
        data_wstrb = 4'b0001 << addr_q[1:0];
        data_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{wdata_q[15:0]}};
      end
      default: data_wstrb = 4'b1111;
    endcase
    if (!wr_q) data_wstrb = 4'b0000;
  end

  assign mem_stall = (state_q == S_REQ) || (state_q == S_WAIT) || accept ||
                     (state_q == S_DISCARD && op_mem) ||
                     (state_q == S_DONE && !mem_adv);

endmodule

// File: tb/tb_mem_data_req.sv
// Scoreboard bench for mem_data_req: the driver pushes expected bus requests and load
// results computed from byte-lane arithmetic; a negedge monitor pops and compares them.
module tb_mem_data_req;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_valid, exe_sign, exe_except, mem_flush, mem_adv;
  logic [1:0]  exe_op, exe_size;
  logic [31:0] exe_addr, exe_wdata;
  logic        mem_ade, mem_stall, load_valid;
  logic [31:0] load_result;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] res_q[$];

  always #5 clk = ~clk;

  mem_data_req dut (
    .clk(clk), .resetn(resetn),
    .exe_valid(exe_valid), .exe_op(exe_op), .exe_size(exe_size), .exe_sign(exe_sign),
    .exe_addr(exe_addr), .exe_wdata(exe_wdata), .exe_except(exe_except),
    .mem_flush(mem_flush), .mem_adv(mem_adv),
    .mem_ade(mem_ade), .mem_stall(mem_stall),
    .load_valid(load_valid), .load_result(load_result),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic check(input string name, input logic [31:0] exp, input logic [31:0] act);
    tests++;
    if (exp !== act) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic req_t model_req(input logic wr, input logic [1:0] size,
                                     input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    int   n   = nbytes(size);
    int   off = int'(addr[1:0]);
    r.wr = wr; r.size = size; r.addr = addr; r.strb = 4'b0000; r.wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (wr && i >= off && i < off + n) r.strb[i] = 1'b1;
      r.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] r   = 32'd0;
    int          n   = nbytes(size);
    int          off = int'(addr[1:0]);
    for (int i = 0; i < n; i++) r[8*i +: 8] = rdata[8*(off + i) +: 8];
    if (sign && r[8*n-1])
      for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;
  logic prev_lv  = 1'b0;
  req_t cur;

  always @(negedge clk) begin
    if (resetn) begin
      if (data_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_req: got addr 0x%08h, expected no request", data_addr);
        end else begin
          cur = exp_q.pop_front();
          check("req_wr",    {31'd0, cur.wr}, {31'd0, data_wr});
          check("req_size",  {30'd0, cur.size}, {30'd0, data_size});
          check("req_addr",  cur.addr, data_addr);
          check("req_wstrb", {28'd0, cur.strb}, {28'd0, data_wstrb});
          if (cur.wr) check("req_wdata", cur.wdata, data_wdata);
        end
      end else if (data_req && prev_req) begin
        check("hold_addr",  cur.addr, data_addr);
        check("hold_wstrb", {28'd0, cur.strb}, {28'd0, data_wstrb});
        if (cur.wr) check("hold_wdata", cur.wdata, data_wdata);
      end
      if (load_valid && !prev_lv) begin
        if (res_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_load_valid: got result 0x%08h, expected none", load_result);
        end else begin
          check("load_result", res_q.pop_front(), load_result);
        end
      end
      prev_req <= data_req;
      prev_lv  <= load_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic exc);
    exe_valid = 1'b1; exe_op = op; exe_size = size; exe_sign = sign;
    exe_addr = addr; exe_wdata = wdata; exe_except = exc;
  endtask

  task automatic expect_issue(input logic [1:0] op, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata);
    exp_q.push_back(model_req(op == 2'b10, size, addr, wdata));
    if (op == 2'b01) res_q.push_back(model_load(size, sign, addr, rdata));
  endtask

  // One complete operation from IDLE back to IDLE with mem_adv held high.
  task automatic do_op(input logic [1:0] op, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic exc,
                       input logic [31:0] rdata, input int a_dly, input int d_dly);
    bit is_mem = (op == 2'b01 || op == 2'b10);
    bit ade    = is_mem && misaligned(size, addr);
    bit issue  = is_mem && !ade && !exc;
    mem_adv = 1'b1;
    drive(op, size, sign, addr, wdata, exc);
    #1;
    check("mem_ade", {31'd0, ade}, {31'd0, mem_ade});
    check("stall_accept", {31'd0, issue}, {31'd0, mem_stall});
    if (issue) expect_issue(op, size, sign, addr, wdata, rdata);
    tick();
    exe_valid = 1'b0;
    if (!issue) begin
      check("no_req", 32'd0, {31'd0, data_req});
      tick();
      check("no_req_later", 32'd0, {31'd0, data_req});
      return;
    end
    repeat (a_dly) begin
      check("stall_req", 32'd1, {31'd0, mem_stall});
      tick();
    end
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    repeat (d_dly) begin
      check("req_low_in_wait", 32'd0, {31'd0, data_req});
      tick();
    end
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    check("stall_wait", 32'd1, {31'd0, mem_stall});
    tick();
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    #1;
    check("load_valid_done", {31'd0, op == 2'b01}, {31'd0, load_valid});
    check("stall_done_adv", 32'd0, {31'd0, mem_stall});
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    exe_valid = 1'b0; exe_op = 2'b00; exe_size = 2'd0; exe_sign = 1'b0;
    exe_addr = 32'd0; exe_wdata = 32'd0; exe_except = 1'b0;
    mem_flush = 1'b0; mem_adv = 1'b1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    #12;
    check("rst_data_req",   32'd0, {31'd0, data_req});
    check("rst_load_valid", 32'd0, {31'd0, load_valid});
    check("rst_load_result", 32'd0, load_result);
    check("rst_mem_stall",  32'd0, {31'd0, mem_stall});
    check("rst_wstrb",      32'd0, {28'd0, data_wstrb});
    check("rst_addr",       32'd0, data_addr);
    check("rst_wdata",      32'd0, data_wdata);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Directed operations from the plan
    do_op(2'b01, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b0, 32'hDEADBEEF, 0, 0);
    do_op(2'b01, 2'd0, 1'b1, 32'h1003, 32'h0, 1'b0, 32'h80FF0000, 1, 1);
    do_op(2'b01, 2'd1, 1'b0, 32'h1002, 32'h0, 1'b0, 32'h80FF0000, 0, 2);
    do_op(2'b10, 2'd0, 1'b0, 32'h2001, 32'h000000AB, 1'b0, 32'h0, 0, 0);
    do_op(2'b10, 2'd1, 1'b0, 32'h2002, 32'h1234ABCD, 1'b0, 32'h0, 2, 0);
    do_op(2'b01, 2'd2, 1'b0, 32'h3002, 32'h0, 1'b0, 32'h0, 0, 0);
    do_op(2'b01, 2'd2, 1'b0, 32'h3000, 32'h0, 1'b1, 32'h0, 0, 0);

    // Flush in WAIT with a new load pending: stale response must be dropped
    drive(2'b01, 2'd2, 1'b0, 32'h4000, 32'h0, 1'b0);
    exp_q.push_back(model_req(1'b0, 2'd2, 32'h4000, 32'h0));
    tick();
    exe_valid = 1'b0;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    mem_flush = 1'b1;
    drive(2'b01, 2'd2, 1'b0, 32'h5000, 32'h0, 1'b0);
    tick();
    mem_flush = 1'b0;
    #1;
    check("discard_stall", 32'd1, {31'd0, mem_stall});
    check("discard_no_req", 32'd0, {31'd0, data_req});
    tick();
    data_data_ok = 1'b1;
    data_rdata   = 32'h11111111;
    expect_issue(2'b01, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h12345678);
    tick();
    data_data_ok = 1'b0;
    check("stale_load_valid", 32'd0, {31'd0, load_valid});
    check("idle_no_req", 32'd0, {31'd0, data_req});
    tick();
    exe_valid = 1'b0;
    check("new_req_after_idle", 32'd1, {31'd0, data_req});
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h12345678;
    tick();
    data_data_ok = 1'b0;
    tick();

    // addr_ok withheld; bus outputs must hold, then a flush withdraws the request
    drive(2'b10, 2'd1, 1'b0, 32'h6002, 32'h1234ABCD, 1'b0);
    exp_q.push_back(model_req(1'b1, 2'd1, 32'h6002, 32'h1234ABCD));
    tick();
    exe_valid = 1'b0;
    tick();
    tick();
    mem_flush = 1'b1;
    tick();
    mem_flush = 1'b0;
    check("flush_req_drop", 32'd0, {31'd0, data_req});
    check("flush_idle_stall", 32'd0, {31'd0, mem_stall});
    tick();
    check("flush_stays_idle", 32'd0, {31'd0, data_req});

    // Held DONE, then back-to-back accept straight into REQ
    drive(2'b01, 2'd2, 1'b0, 32'h7000, 32'h0, 1'b0);
    expect_issue(2'b01, 2'd2, 1'b0, 32'h7000, 32'h0, 32'hCAFEF00D);
    tick();
    exe_valid = 1'b0;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFEF00D;
    mem_adv = 1'b0;
    tick();
    data_data_ok = 1'b0;
    check("done_hold_stall", 32'd1, {31'd0, mem_stall});
    tick();
    check("done_hold_lv", 32'd1, {31'd0, load_valid});
    mem_adv = 1'b1;
    drive(2'b10, 2'd2, 1'b0, 32'h7004, 32'h55AA55AA, 1'b0);
    expect_issue(2'b10, 2'd2, 1'b0, 32'h7004, 32'h55AA55AA, 32'h0);
    #1;
    check("b2b_stall", 32'd1, {31'd0, mem_stall});
    tick();
    exe_valid = 1'b0;
    check("b2b_req", 32'd1, {31'd0, data_req});
    check("b2b_lv_low", 32'd0, {31'd0, load_valid});
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    tick();

    // Randomized operations against the model
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op   = 2'($urandom_range(3, 0));
      logic [1:0]  size = 2'($urandom_range(3, 0));
      logic        sign = 1'($urandom_range(1, 0));
      logic [31:0] addr = $urandom;
      logic        exc  = ($urandom_range(9, 0) == 0);
      if ($urandom_range(1, 0) == 1) addr[1:0] = 2'b00;
      do_op(op, size, sign, addr, $urandom, exc, $urandom,
            $urandom_range(3, 0), $urandom_range(3, 0));
    end

    tick();
    check("exp_q_drained", 32'd0, exp_q.size());
    check("res_q_drained", 32'd0, res_q.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
